// File: rtl/sim_mem_model_pkg.sv
// sim_mem_model_pkg: shared response type, error encoding and address helper
// for the simulation main-memory model.
`default_nettype none

package sim_mem_model_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_ID_W   = 4;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

  typedef struct packed {
    logic [MEM_ID_W-1:0]   id;
    logic                  err;
    logic [MEM_DATA_W-1:0] rdata;
  } mem_resp_t;

  // Number of low address bits that select a byte within one data word.
  function automatic int align_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: shift-register FIFO whose head is always slot 0, so the outputs
// come straight from flops; supports simultaneous push/pop when full.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] slots [DEPTH];
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic [IDX_W-1:0] wr_idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[0];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // When popping, everything shifts down one slot, so the tail moves with it.
  assign wr_idx  = do_pop ? IDX_W'(count - 1'b1) : IDX_W'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) slots[i] <= slots[i+1];
      end
      if (do_push) slots[wr_idx] <= din;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && full && !pop));
  end

endmodule

`default_nettype wire

// File: rtl/sim_mem_model.sv
// sim_mem_model: fixed-latency, in-order, credit-limited main-memory model
// with valid/ready request and response channels.
`default_nettype none

module sim_mem_model
  import sim_mem_model_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int DEPTH_WORDS     = 4096,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [ID_W-1:0]     req_id,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [ID_W-1:0]     resp_id,
  output logic                resp_err
);

  localparam int SHIFT  = align_shift(DATA_W);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int RESP_W = ID_W + 1 + DATA_W;
  localparam int ENT_W  = 1 + RESP_W;
  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              ready_en;
  logic [CRED_W-1:0] outstanding;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] word_idx;
  logic              addr_err;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rdata_sample;
  logic [ENT_W-1:0]  new_entry;
  logic [ENT_W-1:0]  tail_entry;
  logic [RESP_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  // ready_en holds req_ready low during reset and releases it on the first edge after.
  assign req_ready = ready_en && (outstanding < CRED_W'(MAX_OUTSTANDING));
  assign accept    = req_valid && req_ready;
  assign resp_valid = !fifo_empty;
  assign pop       = resp_valid && resp_ready;

  assign word_idx = req_addr >> SHIFT;
  assign addr_err = ((req_addr & ADDR_W'((1 << SHIFT) - 1)) != '0) ||
                    (word_idx >= ADDR_W'(DEPTH_WORDS));
  assign mem_idx  = word_idx[IDX_W-1:0];

  assign rdata_sample = (req_we || addr_err) ? '0 : mem[mem_idx];
  assign new_entry    = {accept, req_id, addr_err ? ERR_ADDR : ERR_NONE, rdata_sample};

  always_ff @(posedge clk) begin
    if (accept && req_we && !addr_err) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (req_wstrb[b]) mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      outstanding <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !accept) outstanding <= outstanding - 1'b1;
    end
  end

  // The FIFO push acts as the last latency stage, so LATENCY-1 flop stages precede it.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign tail_entry = new_entry;
    end else begin : g_pipe
      logic [ENT_W-1:0] stage [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < LATENCY - 1; s++) stage[s] <= '0;
        end else begin
          stage[0] <= new_entry;
          for (int s = 1; s < LATENCY - 1; s++) stage[s] <= stage[s-1];
        end
      end

      assign tail_entry = stage[LATENCY-2];
    end
  endgenerate

  sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail_entry[ENT_W-1]),
    .din   (tail_entry[RESP_W-1:0]),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {resp_id, resp_err, resp_rdata} = fifo_head;

  // Credits already bound occupancy; fullness is only watched by the FIFO's own check.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

`default_nettype wire
